// File: rtl/apb_master_if.sv
// Bundles the command/response handshake and the APB bus of apb_master.
// The master modport is the view of apb_master itself; the slave modport is
// the view of whatever sits on the other side.
interface apb_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Command side
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    // Response side
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    // APB bus
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_master.sv
// APB master: accepts one command at a time, runs it as an APB
// SETUP/ACCESS transfer and returns a single-cycle response pulse.
// A transfer whose slave never raises PREADY is aborted after TIMEOUT
// ACCESS cycles and reported as an error.
module apb_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         PCLK,
    input  logic         PRESET,
    apb_master_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    // Last wait-counter value at which a still-missing PREADY aborts the
    // transfer; counting starts at 0 so this gives TIMEOUT ACCESS cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t            state_r;
    logic [7:0]        wait_cnt_r;
    logic              cmd_ready_r;
    logic              psel_r;
    logic              penable_r;
    logic              pwrite_r;
    logic [ADDR_W-1:0] paddr_r;
    logic [DATA_W-1:0] pwdata_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;
    logic              rsp_err_r;

    // All outputs come straight from registers.
    assign bus.cmd_ready = cmd_ready_r;
    assign bus.PSEL      = psel_r;
    assign bus.PENABLE   = penable_r;
    assign bus.PWRITE    = pwrite_r;
    assign bus.PADDR     = paddr_r;
    assign bus.PWDATA    = pwdata_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;
    assign bus.rsp_err   = rsp_err_r;

    // Transfer state machine with registered APB and response outputs.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_r     <= ST_IDLE;
            wait_cnt_r  <= 8'd0;
            cmd_ready_r <= 1'b0;
            psel_r      <= 1'b0;
            penable_r   <= 1'b0;
            pwrite_r    <= 1'b0;
            paddr_r     <= {ADDR_W{1'b0}};
            pwdata_r    <= {DATA_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            // The response strobe is a one-cycle pulse unless re-armed below.
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.cmd_valid && cmd_ready_r) begin
                        // Address/data/direction stay frozen until the next
                        // handshake, so they are stable through SETUP+ACCESS
                        // and still show the last transfer while idle.
                        pwrite_r    <= bus.cmd_write;
                        paddr_r     <= bus.cmd_addr;
                        pwdata_r    <= bus.cmd_wdata;
                        psel_r      <= 1'b1;
                        penable_r   <= 1'b0;
                        cmd_ready_r <= 1'b0;
                        state_r     <= ST_SETUP;
                    end else begin
                        // Ready rises on the first edge after reset release.
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    psel_r     <= 1'b1;
                    penable_r  <= 1'b1;
                    wait_cnt_r <= 8'd0;
                    state_r    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (bus.PREADY) begin
                        // Normal completion; wins over a coincident timeout.
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= bus.PSLVERR;
                        rsp_rdata_r <= pwrite_r ? {DATA_W{1'b0}} : bus.PRDATA;
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        // Slave never answered: abort with an error response.
                        rsp_valid_r <= 1'b1;
                        rsp_err_r   <= 1'b1;
                        rsp_rdata_r <= {DATA_W{1'b0}};
                        psel_r      <= 1'b0;
                        penable_r   <= 1'b0;
                        cmd_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                        state_r    <= ST_ACCESS;
                    end
                end
                default: begin
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    cmd_ready_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: a behavioural APB slave with a
// programmable wait count, plus a reference memory that predicts every
// response from the command sequence alone.
module tb_apb_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic clk;
    logic rst;

    apb_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK   (clk),
        .PRESET (rst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Slave configuration: ready on ACCESS cycle slave_wait+1, never if < 0.
    int          slave_wait = 0;
    bit          slave_err  = 1'b0;
    logic [31:0] slave_mem [bit [31:0]];

    // Reference memory: what reads must return.
    logic [31:0] exp_mem [bit [31:0]];

    // Monitor observations.
    int          acc_cnt   = 0;
    int          last_acc  = 0;
    int          low_run   = 0;
    int          unstable  = 0;
    int          rsp_cnt   = 0;
    int          gaps [$];
    logic [31:0] rsp_rd_q [$];
    logic        rsp_er_q [$];
    logic [31:0] seen_addr, seen_wdata;
    logic        seen_write;

    // Monitor and APB slave, evaluated at each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.PSEL && !bus.PENABLE) begin
                gaps.push_back(low_run);
                low_run    = 0;
                acc_cnt    = 0;
                seen_addr  = bus.PADDR;
                seen_wdata = bus.PWDATA;
                seen_write = bus.PWRITE;
            end else if (bus.PSEL && bus.PENABLE) begin
                acc_cnt++;
                if (bus.PADDR !== seen_addr || bus.PWDATA !== seen_wdata || bus.PWRITE !== seen_write)
                    unstable++;
            end else begin
                low_run++;
            end
            if (bus.rsp_valid === 1'b1) begin
                rsp_cnt++;
                last_acc = acc_cnt;
                rsp_rd_q.push_back(bus.rsp_rdata);
                rsp_er_q.push_back(bus.rsp_err);
            end
            if (bus.PSEL && bus.PENABLE) begin
                bus.PREADY  = (slave_wait >= 0) && (acc_cnt == slave_wait + 1);
                bus.PSLVERR = slave_err;
                bus.PRDATA  = slave_mem.exists(bus.PADDR) ? slave_mem[bus.PADDR] : 32'h0;
                if (bus.PREADY && bus.PWRITE) slave_mem[bus.PADDR] = bus.PWDATA;
            end else begin
                // Junk outside ACCESS must be ignored by the master.
                bus.PREADY  = 1'($urandom_range(0, 1));
                bus.PSLVERR = 1'($urandom_range(0, 1));
                bus.PRDATA  = $urandom;
            end
        end
    end

    // Watchdog against a hung run.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present a command and wait (bounded) until it has been accepted.
    task automatic issue(input bit w, input bit [31:0] a, input bit [31:0] d, output bit ok);
        int i;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < 100) begin
            if (bus.cmd_ready === 1'b1) ok = 1'b1;
            step();
            i++;
        end
    endtask

    // One complete transfer, checked against the reference model.
    task automatic xfer(input bit w, input bit [31:0] a, input bit [31:0] d,
                        input int waits, input bit err, input string name);
        bit          to, ok;
        int          acc_exp, lat, rc0;
        logic [31:0] exp_rd, got_rd;
        logic        exp_er, got_er;
        to      = (waits < 0) || (waits > TIMEOUT - 1);
        acc_exp = to ? TIMEOUT : waits + 1;
        exp_er  = to ? 1'b1 : err;
        exp_rd  = (w || to) ? 32'h0 : (exp_mem.exists(a) ? exp_mem[a] : 32'h0);
        if (w && !to) exp_mem[a] = d;
        slave_wait = waits;
        slave_err  = err;
        rc0        = rsp_cnt;
        rsp_rd_q.delete();
        rsp_er_q.delete();
        unstable = 0;
        issue(w, a, d, ok);
        bus.cmd_valid = 1'b0;
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL %s accept: cmd_ready never seen, required 1", name); end
        lat = 0;
        while (rsp_cnt == rc0 && lat < 300) begin step(); lat++; end
        got_rd = (rsp_rd_q.size() > 0) ? rsp_rd_q[0] : 32'hx;
        got_er = (rsp_er_q.size() > 0) ? rsp_er_q[0] : 1'bx;
        vectors++;
        if (lat !== acc_exp + 1) begin miscompares++; $display("FAIL %s latency: got %0d required %0d", name, lat, acc_exp + 1); end
        vectors++;
        if (last_acc !== acc_exp) begin miscompares++; $display("FAIL %s access_cycles: got %0d required %0d", name, last_acc, acc_exp); end
        vectors++;
        if (got_rd !== exp_rd) begin miscompares++; $display("FAIL %s rsp_rdata: got %h required %h", name, got_rd, exp_rd); end
        vectors++;
        if (got_er !== exp_er) begin miscompares++; $display("FAIL %s rsp_err: got %b required %b", name, got_er, exp_er); end
        vectors++;
        if (seen_addr !== a || seen_write !== w || seen_wdata !== d) begin
            miscompares++;
            $display("FAIL %s apb_fields: got addr=%h w=%b d=%h required addr=%h w=%b d=%h",
                     name, seen_addr, seen_write, seen_wdata, a, w, d);
        end
        vectors++;
        if (unstable !== 0) begin miscompares++; $display("FAIL %s stability: got %0d changes required 0", name, unstable); end
        step();
        vectors++;
        if (rsp_cnt !== rc0 + 1 || bus.rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s pulse: got %0d pulses rsp_valid=%b required 1 pulse rsp_valid=0", name, rsp_cnt - rc0, bus.rsp_valid);
        end
        vectors++;
        if (bus.rsp_rdata !== exp_rd || bus.rsp_err !== exp_er) begin
            miscompares++;
            $display("FAIL %s rsp_hold: got %h/%b required %h/%b", name, bus.rsp_rdata, bus.rsp_err, exp_rd, exp_er);
        end
        vectors++;
        if (bus.PSEL !== 1'b0 || bus.PADDR !== a || bus.PWDATA !== d || bus.PWRITE !== w) begin
            miscompares++;
            $display("FAIL %s idle_retain: got psel=%b addr=%h required psel=0 addr=%h", name, bus.PSEL, bus.PADDR, a);
        end
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_wdata = 32'h0;
        repeat (3) step();
        vectors++;
        if ({bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PWRITE, bus.rsp_valid, bus.rsp_err} !== 6'b0 ||
            bus.PADDR !== 32'h0 || bus.PWDATA !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_values: got ready=%b psel=%b pen=%b addr=%h required all 0",
                     bus.cmd_ready, bus.PSEL, bus.PENABLE, bus.PADDR);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.cmd_ready !== 1'b0) begin miscompares++; $display("FAIL ready_before_edge: got %b required 0", bus.cmd_ready); end
        step();
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_edge: got %b required 1", bus.cmd_ready); end
    endtask

    task automatic test_write_read();
        xfer(1'b1, 32'd4, 32'hDEADBEEF, 1, 1'b0, "wr4");
        xfer(1'b0, 32'd4, 32'h0000_0000, 1, 1'b0, "rd4");
    endtask

    task automatic test_slave_error();
        xfer(1'b1, 32'd3, 32'hA5A5_0003, 0, 1'b1, "wr3_slverr");
        xfer(1'b0, 32'd3, 32'h0, 2, 1'b1, "rd3_slverr");
    endtask

    task automatic test_timeout();
        xfer(1'b0, 32'd4, $urandom, -1, 1'b0, "rd_timeout");
        xfer(1'b1, 32'd4, $urandom, -1, 1'b0, "wr_timeout");
        xfer(1'b0, 32'd4, $urandom, TIMEOUT - 1, 1'b0, "ready_at_limit");
        xfer(1'b0, 32'd4, $urandom, TIMEOUT - 2, 1'b1, "ready_before_limit");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            bit          w;
            bit [31:0]   a, d;
            int          waits;
            bit          err;
            w     = 1'($urandom_range(0, 1));
            a     = 32'($urandom_range(0, 15));
            d     = $urandom;
            waits = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
            err   = ($urandom_range(0, 3) == 0);
            xfer(w, a, d, waits, err, "random");
        end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        int          rc0, k;
        logic [31:0] d [4];
        slave_wait = 0;
        slave_err  = 1'b0;
        rc0        = rsp_cnt;
        rsp_er_q.delete();
        gaps.delete();
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            exp_mem[32'(i * 4)] = d[i];
            issue(1'b1, 32'(i * 4), d[i], ok);
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL b2b accept %0d: cmd_ready never seen, required 1", i); end
        end
        bus.cmd_valid = 1'b0;
        k = 0;
        while (rsp_cnt < rc0 + 4 && k < 100) begin step(); k++; end
        step();
        vectors++;
        if (rsp_cnt !== rc0 + 4) begin miscompares++; $display("FAIL b2b pulses: got %0d required 4", rsp_cnt - rc0); end
        for (int i = 1; i < 4; i++) begin
            int g;
            g = (gaps.size() > i) ? gaps[i] : -1;
            vectors++;
            if (g !== 1) begin miscompares++; $display("FAIL b2b psel_gap %0d: got %0d required 1", i, g); end
        end
        for (int i = 0; i < 4; i++) begin
            logic e;
            e = (rsp_er_q.size() > i) ? rsp_er_q[i] : 1'bx;
            vectors++;
            if (e !== 1'b0) begin miscompares++; $display("FAIL b2b rsp_err %0d: got %b required 0", i, e); end
        end
        for (int i = 0; i < 4; i++)
            xfer(1'b0, 32'(i * 4), $urandom, int'($urandom_range(0, 3)), 1'b0, "b2b_readback");
    endtask

    task automatic test_reset_mid();
        bit ok;
        int rc0;
        slave_wait = -1;
        slave_err  = 1'b0;
        rc0        = rsp_cnt;
        issue(1'b1, 32'd8, 32'h1234_5678, ok);
        bus.cmd_valid = 1'b0;
        repeat (3) step();
        vectors++;
        if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst in_access: got psel=%b pen=%b required 1/1", bus.PSEL, bus.PENABLE);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst async_clear: got psel=%b pen=%b rsp=%b ready=%b required 0",
                     bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.cmd_ready);
        end
        repeat (2) step();
        rst = 1'b0;
        vectors++;
        if (rsp_cnt !== rc0 || bus.PADDR !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL midrst no_rsp: got pulses=%0d paddr=%h required 0/0", rsp_cnt - rc0, bus.PADDR);
        end
        step();
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin miscompares++; $display("FAIL midrst ready: got %b required 1", bus.cmd_ready); end
        xfer(1'b0, 32'd8, $urandom, 0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
